// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass and a per-register
// busy scoreboard that decode uses to detect RAW hazards on in-flight producers.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic                i_issue_en,
  input  logic [AW-1:0]       i_issue_rd,
  input  logic                i_flush,
  output logic [NREG-1:0]     o_busy_vec
);

  if (NWR < 1 || NWR > 4 || NRD < 1 || NREG < 2 || (NREG & (NREG - 1)) != 0) begin : g_param_err
    $error("regfile_mp: NWR must be 1..4, NRD >= 1, NREG a power of 2 >= 2");
  end

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  logic [AW-1:0]   w_rd_addr [NRD];
  logic [XLEN-1:0] w_rd_val  [NRD];
  logic [NRD-1:0]  w_rd_hit;
  logic [AW-1:0]   w_wr_addr [NWR];
  logic [XLEN-1:0] w_wr_data [NWR];
  logic [NWR-1:0]  w_wr_act;

  for (genvar g = 0; g < NWR; g++) begin : g_wr_unpack
    assign w_wr_addr[g] = i_wr_addr[g*AW +: AW];
    assign w_wr_data[g] = i_wr_data[g*XLEN +: XLEN];
  end

  // Bypass is gated by reset so a write presented during reset is invisible.
  assign w_wr_act = i_wr_en & {NWR{i_rst_n}};

  for (genvar g = 0; g < NRD; g++) begin : g_rd_port
    assign w_rd_addr[g]              = i_rd_addr[g*AW +: AW];
    assign o_rd_data[g*XLEN +: XLEN] = w_rd_val[g];
    assign o_rd_busy[g]              = i_rst_n & r_busy[w_rd_addr[g]] & ~w_rd_hit[g];
  end

  // Ascending port order lets the highest-index matching write win the forward.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      w_rd_hit[k] = 1'b0;
      w_rd_val[k] = r_regs[w_rd_addr[k]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (w_wr_act[j] && (w_wr_addr[j] == w_rd_addr[k])) begin
            w_rd_hit[k] = 1'b1;
            w_rd_val[k] = w_wr_data[j];
          end
        end
      end
      if (!i_rst_n || (ZERO_REG != 0 && w_rd_addr[k] == '0)) begin
        w_rd_val[k] = '0;
      end
    end
  end

  // Flush beats issue, issue beats write-completion, so a new producer keeps its bit.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_en[j]) begin
        w_busy_nxt[w_wr_addr[j]] = 1'b0;
      end
    end
    if (i_issue_en) begin
      w_busy_nxt[i_issue_rd] = 1'b1;
    end
    if (i_flush) begin
      w_busy_nxt = '0;
    end
    if (ZERO_REG != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (i_wr_en[j] && !(ZERO_REG != 0 && w_wr_addr[j] == '0)) begin
          r_regs[w_wr_addr[j]] <= w_wr_data[j];
        end
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy_vec = r_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(i_issue_en && i_flush))
        else $warning("regfile_mp: issue and flush in the same cycle, issue discarded");
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with bypass, zero register and two
// write ports, and one with neither bypass nor zero register and a single write port.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [1:0]          wr_en = '0;
  logic [2*AW-1:0]     wr_addr = '0;
  logic [2*XLEN-1:0]   wr_data = '0;
  logic                issue_en = 1'b0;
  logic [AW-1:0]       issue_rd = '0;
  logic                flush = 1'b0;

  logic [NRD*XLEN-1:0] a_rd_data, b_rd_data;
  logic [NRD-1:0]      a_rd_busy, b_rd_busy;
  logic [NREG-1:0]     a_busy_vec, b_busy_vec;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(a_rd_data),
    .o_rd_busy(a_rd_busy), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_issue_en(issue_en), .i_issue_rd(issue_rd), .i_flush(flush), .o_busy_vec(a_busy_vec)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(1), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(b_rd_data),
    .o_rd_busy(b_rd_busy), .i_wr_en(wr_en[0:0]), .i_wr_addr(wr_addr[AW-1:0]),
    .i_wr_data(wr_data[XLEN-1:0]), .i_issue_en(issue_en), .i_issue_rd(issue_rd),
    .i_flush(flush), .o_busy_vec(b_busy_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    wr_en    = '0;
    issue_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[j]               = 1'b1;
    wr_addr[j*AW +: AW]    = a;
    wr_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    // Reset held across an edge with a write and an issue presented.
    tick();
    set_wr(0, 5'd5, 32'hCAFEF00D);
    issue_en = 1'b1;
    issue_rd = 5'd5;
    set_rd(1, 5'd5);
    #1;
    chk("rst_rd_data_bypass_gated", a_rd_data[32 +: 32], 32'h0);
    chk("rst_rd_busy", a_rd_busy, 2'b00);
    tick();
    chk("rst_busy_vec_a", a_busy_vec, 32'h0);
    chk("rst_busy_vec_b", b_busy_vec, 32'h0);
    clr();
    rst_n = 1'b1;

    // Test 1: write r5 on port 0, read on port 1 in the same cycle.
    set_wr(0, 5'd5, 32'hDEADBEEF);
    set_rd(1, 5'd5);
    #1;
    chk("t1_bypass_same_cycle", a_rd_data[32 +: 32], 32'hDEADBEEF);
    chk("t1_nobypass_same_cycle", b_rd_data[32 +: 32], 32'h0);
    tick();
    clr();
    #1;
    chk("t1_nobypass_next_cycle", b_rd_data[32 +: 32], 32'hDEADBEEF);
    chk("t1_stored_a", a_rd_data[32 +: 32], 32'hDEADBEEF);

    // Test 2: write and issue r0.
    set_wr(0, 5'd0, 32'h12345678);
    issue_en = 1'b1;
    issue_rd = 5'd0;
    set_rd(0, 5'd0);
    #1;
    chk("t2_zero_over_bypass", a_rd_data[0 +: 32], 32'h0);
    chk("t2_b_old_value", b_rd_data[0 +: 32], 32'h0);
    tick();
    clr();
    #1;
    chk("t2_zero_read", a_rd_data[0 +: 32], 32'h0);
    chk("t2_zero_busy_vec", a_busy_vec, 32'h0);
    chk("t2_b_r0_stored", b_rd_data[0 +: 32], 32'h12345678);
    chk("t2_b_r0_busy", b_busy_vec, 32'h1);

    // Test 3: both ports write r7, highest index wins.
    set_wr(0, 5'd7, 32'h11111111);
    set_wr(1, 5'd7, 32'h22222222);
    set_rd(0, 5'd7);
    #1;
    chk("t3_bypass_hi_port", a_rd_data[0 +: 32], 32'h22222222);
    tick();
    clr();
    #1;
    chk("t3_stored_hi_port", a_rd_data[0 +: 32], 32'h22222222);
    chk("t3_b_single_port", b_rd_data[0 +: 32], 32'h11111111);

    // Test 4: issue r3, write it two cycles later.
    issue_en = 1'b1;
    issue_rd = 5'd3;
    tick();
    clr();
    #1;
    chk("t4_busy_cycle1", a_busy_vec, 32'h8);
    tick();
    set_wr(0, 5'd3, 32'hA5A5A5A5);
    set_rd(1, 5'd3);
    #1;
    chk("t4_busy_cycle2", a_busy_vec, 32'h8);
    chk("t4_rd_busy_bypassed", a_rd_busy, 2'b00);
    chk("t4_rd_data_bypassed", a_rd_data[32 +: 32], 32'hA5A5A5A5);
    chk("t4_b_rd_busy_no_bypass", b_rd_busy, 2'b10);
    tick();
    clr();
    #1;
    chk("t4_busy_cleared", a_busy_vec, 32'h0);
    chk("t4_b_busy_cleared", b_busy_vec, 32'h1);

    // Test 5: issue and write r9 in the same cycle.
    issue_en = 1'b1;
    issue_rd = 5'd9;
    set_wr(0, 5'd9, 32'h00000099);
    tick();
    clr();
    set_rd(0, 5'd9);
    #1;
    chk("t5_issue_beats_write", a_busy_vec, 32'h200);
    chk("t5_rd_busy", a_rd_busy, 2'b01);
    chk("t5_stored", a_rd_data[0 +: 32], 32'h99);

    // Test 6: issue r1, r2, r4, then flush.
    issue_en = 1'b1;
    issue_rd = 5'd1;
    tick();
    issue_rd = 5'd2;
    tick();
    issue_rd = 5'd4;
    tick();
    clr();
    #1;
    chk("t6_busy_before_flush", a_busy_vec, 32'h216);
    flush = 1'b1;
    tick();
    clr();
    #1;
    chk("t6_flush_a", a_busy_vec, 32'h0);
    chk("t6_flush_b", b_busy_vec, 32'h0);

    // Issue r6, then asynchronous reset mid-cycle.
    issue_en = 1'b1;
    issue_rd = 5'd6;
    tick();
    clr();
    #1;
    chk("t6_busy_r6", a_busy_vec, 32'h40);
    rst_n = 1'b0;
    #1;
    chk("t6_async_busy_a", a_busy_vec, 32'h0);
    chk("t6_async_rd_a", a_rd_data[0 +: 32], 32'h0);
    chk("t6_async_rd_busy", a_rd_busy, 2'b00);
    chk("t6_async_rd_b", b_rd_data[0 +: 32], 32'h0);
    tick();
    rst_n = 1'b1;
    set_rd(1, 5'd7);
    #1;
    chk("t6_after_rst_r9", a_rd_data[0 +: 32], 32'h0);
    chk("t6_after_rst_r7", a_rd_data[32 +: 32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
